ex_stage: RTL
=============

# ex_stage

Execute stage of the MiniRiscV pipeline, sitting directly upstream of the memory stage. It computes the RV32I ALU result, or runs an iterative RV32M multiply/divide, and registers the result with the memory/writeback control bits. Its `ALUResult`, `MemRead`, `MemWrite` and `MemtoReg` outputs drive the memory stage's address and controls. While a multi-cycle operation runs, `busy` stalls the decode stage.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low
- `flush`  in  1  kill in-flight op and output slot (branch redirect)
- `in_valid`  in  1  upstream instruction present
- `is_muldiv`  in  1  instruction is RV32M
- `alu_ctrl`  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, others → 0
- `md_op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `op_a`, `op_b`  in  32  operands
- `store_data_in`  in  32  rs2 value for stores
- `rd_in`  in  5  destination register
- `MemRead_in`, `MemWrite_in`, `MemtoReg_in`, `RegWrite_in`  in  1 each  control pass-through
- `busy`  out  1  stage cannot accept; upstream holds
- `out_valid`  out  1  output slot holds a real instruction
- `ALUResult`  out  32  result / memory address
- `StoreData`  out  32  registered store data
- `rd`  out  5  registered destination
- `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`  out  1 each  registered controls

## Operation
- Accept = `in_valid && !busy`. Inputs are ignored while `busy`=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE, accept, non-muldiv: output registers load at the same edge; stay in IDLE.
  - IDLE, accept, muldiv: latch operands, op and controls; enter RUN with counter=31.
  - RUN: one radix-2 step per cycle. Multiply is shift-add on 33-bit sign/zero-extended magnitudes; divide is restoring on magnitudes. At counter=0, go to DONE.
  - DONE: apply sign fix-up and special cases, load the output registers, return to IDLE.
- `busy` = (state != IDLE).
- Output slot with no accept or completion: `out_valid`=0 and `MemRead`/`MemWrite`/`RegWrite`/`MemtoReg` forced to 0. Data outputs hold their previous values.
- Shifts use `op_b[4:0]`. SLT/SLTU return 0 or 1. PASSB returns `op_b` (LUI).
- MUL returns the low 32 bits of the 64-bit product; MULH/MULHSU/MULHU return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend (signed and unsigned).
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- Special cases keep the same fixed latency; there is no early exit.
- `flush` (with `rst`=1): state → IDLE, `out_valid`=0, control outputs 0. A coincident accept is dropped.
- Reset has priority over flush. Reset mid-RUN aborts the operation.

## Timing
- Reset values: state IDLE, `busy` 0, `out_valid` 0, `ALUResult` 0, `StoreData` 0, `rd` 0, all control outputs 0.
- ALU latency: accept at edge E → outputs valid after E for one cycle.
- Muldiv latency: accept at E0 → `busy` high after E0. Results and `out_valid` load at E0+33 (32 RUN edges plus one DONE edge). `busy` falls after E0+33.
- Back-to-back: the next accept can occur at E0+34. The memory stage sees a one-cycle `out_valid`=1 pulse.
- No combinational path from inputs to outputs except `busy` (state only).

## Configuration
- `RV_M_DIV_EN` defined: DIV/DIVU/REM/REMU run through the iterative divider as above.
- Undefined: the divider logic is omitted. `md_op` 4–7 completes like an ALU op in 1 cycle with `ALUResult`=0 and `RegWrite` forced 0. MUL ops are unchanged.

## Test plan
- Reset: hold `rst`=0 for 2 cycles mid-RUN of a DIV → all outputs 0 and `busy`=0 the cycle after release. The next ADD 3+4 gives `ALUResult`=7.
- ALU sweep: SUB 5−7 → 0xFFFFFFFE; SRA 0x80000000>>4 → 0xF8000000; SLTU 1<0xFFFFFFFF → 1; load with ADD 0x100+4 and `MemRead_in`=1 → `MemRead`=1, `ALUResult`=0x104, one-cycle `out_valid`.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHU of the same operands → 0xFFFFFFFE; `out_valid` exactly 33 edges after accept; `busy` high throughout RUN.
- DIV −7/2 → −3, REM −7/2 → −1; DIVU 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/−1 → 0x80000000 with REM 0.
- `in_valid` held high with a new op while `busy` → ignored; accepted at E0+34. Flush at E0+10 of a MUL → no `out_valid` pulse and `busy` low next cycle.
- With `RV_M_DIV_EN` undefined: DIVU 10/3 → 1-cycle result, `ALUResult`=0, `RegWrite`=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage - MiniRiscV execute stage.
//
// Computes the RV32I ALU result in one cycle, or runs an iterative RV32M
// multiply (shift-add) / divide (restoring) over 32 RUN cycles plus one DONE
// cycle. The result is registered together with the memory/writeback control
// bits that feed the memory stage.
//
// Configuration macro: RV_M_DIV_EN
//   defined   - DIV/DIVU/REM/REMU use the iterative divider.
//   undefined - no divider; md_op 4..7 retire in one cycle with ALUResult=0
//               and RegWrite=0.
//
// Ports
//   clk, rst (sync, active-low), flush (kills in-flight op and output slot)
//   in_valid, is_muldiv, alu_ctrl[3:0], md_op[2:0], op_a, op_b,
//   store_data_in, rd_in, MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in
//   busy (state != IDLE), out_valid, ALUResult, StoreData, rd,
//   MemRead, MemWrite, MemtoReg, RegWrite
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        is_muldiv,
  input  logic [3:0]  alu_ctrl,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] ALUResult,
  output logic [31:0] StoreData,
  output logic [4:0]  rd,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef RV_M_DIV_EN
  localparam int OPW = 3;
`else
  localparam int OPW = 2;
`endif

  state_t          state;
  logic [4:0]      cnt;
  logic [63:0]     prod;   // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0]     mop;    // multiplicand / divisor magnitude
  logic [OPW-1:0]  op_q;
  logic            neg_q;  // product / quotient must be negated
  logic            mr_q, mw_q, m2r_q, rw_q;
  logic [4:0]      rd_q;
  logic [31:0]     sd_q;
`ifdef RV_M_DIV_EN
  logic            neg_r;  // remainder takes the dividend's sign
  logic            div0_q;
  logic            ovf_q;
  logic [31:0]     a_raw;
`endif

  logic        accept, md_start, alu_load;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] alu_res;
  logic [63:0] step;
  logic [32:0] acc;
  logic [63:0] mul_full;
  logic [31:0] md_res;
`ifdef RV_M_DIV_EN
  logic [32:0] shl;
  logic [33:0] diff;
  logic [31:0] q_res, r_res;
`endif

  assign busy   = (state != IDLE);
  assign accept = in_valid && !busy;
`ifdef RV_M_DIV_EN
  assign md_start = accept && is_muldiv;
`else
  // Without a divider, divide ops fall through the single-cycle path.
  assign md_start = accept && is_muldiv && !md_op[2];
`endif
  assign alu_load = accept && !md_start;

  // Operand signedness: MULH/MULHSU/DIV/REM treat op_a as signed,
  // MULH/DIV/REM treat op_b as signed. MUL low half is sign-agnostic.
  assign a_signed = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
  assign b_signed = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
  assign a_neg    = a_signed && op_a[31];
  assign b_neg    = b_signed && op_b[31];
  assign a_mag    = a_neg ? (~op_a + 32'd1) : op_a;
  assign b_mag    = b_neg ? (~op_b + 32'd1) : op_b;

  always_comb begin
    alu_res = '0;
    if (!is_muldiv) begin
      case (alu_ctrl)
        4'd0:    alu_res = op_a + op_b;
        4'd1:    alu_res = op_a - op_b;
        4'd2:    alu_res = op_a << op_b[4:0];
        4'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
        4'd4:    alu_res = {31'b0, op_a < op_b};
        4'd5:    alu_res = op_a ^ op_b;
        4'd6:    alu_res = op_a >> op_b[4:0];
        4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
        4'd8:    alu_res = op_a | op_b;
        4'd9:    alu_res = op_a & op_b;
        4'd10:   alu_res = op_b;
        default: alu_res = '0;
      endcase
    end
  end

  // One radix-2 iteration of the running operation.
  always_comb begin
    acc  = '0;
    step = prod;
`ifdef RV_M_DIV_EN
    shl  = '0;
    diff = '0;
    if (op_q[2]) begin
      shl  = {prod[63:32], prod[31]};
      diff = {1'b0, shl} - {2'b0, mop};
      if (!diff[33]) step = {diff[31:0], prod[30:0], 1'b1};
      else           step = {shl[31:0], prod[30:0], 1'b0};
    end else
`endif
    begin
      acc  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mop} : 33'd0);
      step = {acc, prod[31:1]};
    end
  end

  // Sign fix-up and special cases applied in DONE.
  always_comb begin
    mul_full = neg_q ? (~prod + 64'd1) : prod;
    md_res   = (op_q[1:0] == 2'd0) ? mul_full[31:0] : mul_full[63:32];
`ifdef RV_M_DIV_EN
    q_res = neg_q ? (~prod[31:0] + 32'd1) : prod[31:0];
    r_res = neg_r ? (~prod[63:32] + 32'd1) : prod[63:32];
    if (div0_q) begin
      q_res = 32'hFFFF_FFFF;
      r_res = a_raw;
    end else if (ovf_q) begin
      q_res = 32'h8000_0000;
      r_res = 32'd0;
    end
    if (op_q[2]) md_res = op_q[1] ? r_res : q_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prod      <= '0;
      mop       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= '0;
      sd_q      <= '0;
`ifdef RV_M_DIV_EN
      neg_r     <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      a_raw     <= '0;
`endif
      out_valid <= 1'b0;
      ALUResult <= '0;
      StoreData <= '0;
      rd        <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      RegWrite  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      RegWrite  <= 1'b0;
    end else begin
      // Empty slot by default; data outputs hold.
      out_valid <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      RegWrite  <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            state <= RUN;
            cnt   <= 5'd31;
            prod  <= {32'd0, a_mag};
            mop   <= b_mag;
            op_q  <= md_op[OPW-1:0];
            neg_q <= a_neg ^ b_neg;
            mr_q  <= MemRead_in;
            mw_q  <= MemWrite_in;
            m2r_q <= MemtoReg_in;
            rw_q  <= RegWrite_in;
            rd_q  <= rd_in;
            sd_q  <= store_data_in;
`ifdef RV_M_DIV_EN
            neg_r  <= a_neg;
            div0_q <= (op_b == 32'd0);
            ovf_q  <= !md_op[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
            a_raw  <= op_a;
`endif
          end else if (alu_load) begin
            out_valid <= 1'b1;
            ALUResult <= alu_res;
            StoreData <= store_data_in;
            rd        <= rd_in;
            MemRead   <= MemRead_in;
            MemWrite  <= MemWrite_in;
            MemtoReg  <= MemtoReg_in;
            // Only reachable with is_muldiv when the divider is absent.
            RegWrite  <= RegWrite_in && !is_muldiv;
          end
        end
        RUN: begin
          prod <= step;
          if (cnt == 5'd0) state <= DONE;
          else             cnt   <= cnt - 5'd1;
        end
        DONE: begin
          state     <= IDLE;
          out_valid <= 1'b1;
          ALUResult <= md_res;
          StoreData <= sd_q;
          rd        <= rd_q;
          MemRead   <= mr_q;
          MemWrite  <= mw_q;
          MemtoReg  <= m2r_q;
          RegWrite  <= rw_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
